// File: rtl/prng_tap_collector.sv
// Collects distinct non-zero tap positions from the PRNG byte stream into an
// ascending set and offers it downstream over a valid/ready handshake.
module prng_tap_collector #(
    parameter int unsigned COUNT     = 4,
    parameter int unsigned COEF_BITS = 5,
    parameter int unsigned W_IN      = 8
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [W_IN-1:0]               din,
    input  logic                          din_done,
    output logic [COUNT*COEF_BITS-1:0]    coef_flat,
    output logic                          set_valid,
    input  logic                          set_ready,
    output logic [$clog2(COUNT+1)-1:0]    fill_level,
    output logic [7:0]                    dup_cnt
);

    localparam int unsigned FW = $clog2(COUNT + 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [COEF_BITS-1:0] slot_q [COUNT];
    logic [COEF_BITS-1:0] slot_d [COUNT];
    logic [FW-1:0]        fill_q, fill_d;
    logic [7:0]           dup_q, dup_d;
    logic                 done_q;
    logic                 strobe;
    logic [COEF_BITS-1:0] v;
    logic                 hit;
    logic [FW-1:0]        pos;

    assign strobe = din_done & ~done_q;
    assign v      = din[COEF_BITS-1:0];

    generate
        if (W_IN > COEF_BITS) begin : g_din_hi
            logic din_unused;
            assign din_unused = ^din[W_IN-1:COEF_BITS];
        end
    endgenerate

    // Membership test and insert position use only the filled prefix of the slots
    always_comb begin
        hit = 1'b0;
        pos = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (FW'(i) < fill_q) begin
                if (slot_q[i] == v) hit = 1'b1;
                if (slot_q[i] < v)  pos = pos + FW'(1);
            end
        end
    end

    // Next-state and next-data logic
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        dup_d   = dup_q;
        for (int i = 0; i < COUNT; i++) slot_d[i] = slot_q[i];

        case (state_q)
            S_FILL: begin
                if (strobe && (v != '0)) begin
                    if (hit) begin
                        if (dup_q != 8'hFF) dup_d = dup_q + 8'd1;
                    end else begin
                        // Slots at or above the insert point move up one index
                        for (int i = 0; i < COUNT; i++) begin
                            if (FW'(i) == pos) begin
                                slot_d[i] = v;
                            end else if (FW'(i) > pos) begin
                                slot_d[i] = slot_q[(i == 0) ? 0 : i - 1];
                            end
                        end
                        fill_d = fill_q + FW'(1);
                        if (fill_q == FW'(COUNT - 1)) state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (set_ready) begin
                    for (int i = 0; i < COUNT; i++) slot_d[i] = '0;
                    fill_d  = '0;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= S_FILL;
            fill_q    <= '0;
            dup_q     <= '0;
            done_q    <= 1'b0;
            set_valid <= 1'b0;
            for (int i = 0; i < COUNT; i++) slot_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            dup_q     <= dup_d;
            done_q    <= din_done;
            set_valid <= (state_d == S_FULL);
            for (int i = 0; i < COUNT; i++) slot_q[i] <= slot_d[i];
        end
    end

    always_comb begin
        coef_flat = '0;
        for (int i = 0; i < COUNT; i++) coef_flat[i*COEF_BITS +: COEF_BITS] = slot_q[i];
    end

    assign fill_level = fill_q;
    assign dup_cnt    = dup_q;

endmodule
